// File: rtl/approx_mult_err_monitor_pkg.sv
// Shared types and widths for the approximate-multiplier error monitor family.
package approx_mult_pkg;

    // Operand and product widths of the multiplier under test.
    localparam int OP_W      = 4;
    localparam int P_W       = 8;
    localparam int IDX_W     = 2 * OP_W;
    localparam int NUM_PAIRS = 1 << IDX_W;

    // Accumulator widths, sized so a full sweep cannot overflow.
    localparam int SUM_ABS_W      = 16;
    localparam int ERR_CNT_W      = IDX_W + 1;
    localparam int SUM_REL_INT_W  = 16;
    localparam int MEAN_REL_INT_W = SUM_REL_INT_W - IDX_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_APPLY,
        ST_SAMPLE,
        ST_DIVIDE,
        ST_ACCUM,
        ST_DONE
    } state_e;

    // Quotient width of |p - exact| / exact in Q8.frac_bits.
    function automatic int quot_width(input int frac_bits);
        return P_W + frac_bits;
    endfunction

endpackage

// File: rtl/approx_mult_err_monitor_seq_restoring_div.sv
// Sequential restoring divider: one quotient bit per cycle, quotient only.
// The first bit is produced on the start edge, so valid pulses DVD_W-1
// edges after start. DVD_W must be at least 2; divisor is never zero.
module seq_restoring_div #(
    parameter int DVD_W = 20,
    parameter int DVS_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic             valid,
    output logic [DVD_W-1:0] quotient
);

    localparam int CNT_W = $clog2(DVD_W + 1);

    logic [DVS_W-1:0] rem_q, rem_d;
    logic [DVD_W-1:0] quo_q, quo_d;
    logic [DVS_W-1:0] dvs_q, dvs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             run_q, run_d;
    logic             valid_q, valid_d;

    logic [DVS_W-1:0] rem_src;
    logic [DVD_W-1:0] quo_src;
    logic [DVS_W-1:0] dvs_src;
    logic [DVS_W:0]   trial;

    // One restoring step per cycle; the dividend shifts out as quotient bits shift in.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, otherwise paths that skip it infer latches.
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        run_d   = run_q;
        valid_d = 1'b0;
        rem_src = start ? '0 : rem_q;
        quo_src = start ? dividend : quo_q;
        dvs_src = start ? divisor : dvs_q;
        trial   = {rem_src, quo_src[DVD_W-1]};
        if (start || run_q) begin
            if (trial >= {1'b0, dvs_src}) begin
                rem_d = trial[DVS_W-1:0] - dvs_src;
                quo_d = {quo_src[DVD_W-2:0], 1'b1};
            end else begin
                rem_d = trial[DVS_W-1:0];
                quo_d = {quo_src[DVD_W-2:0], 1'b0};
            end
            dvs_d = dvs_src;
            if (start) begin
                cnt_d = CNT_W'(DVD_W - 1);
                run_d = 1'b1;
            end else begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    run_d   = 1'b0;
                    valid_d = 1'b1;
                end
            end
        end
    end

    // Divider state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            run_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            run_q   <= run_d;
            valid_q <= valid_d;
        end
    end

    assign valid    = valid_q;
    assign quotient = quo_q;

endmodule

// File: rtl/approx_mult_err_monitor.sv
// Sweeps all 4x4 operand pairs through an external approximate multiplier
// and accumulates absolute, maximum and fixed-point relative error.
module approx_mult_err_monitor
    import approx_mult_pkg::*;
#(
    parameter int FRAC_BITS     = 12,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                start,
    output logic                                busy,
    output logic                                done,
    output logic [OP_W-1:0]                     mult_a,
    output logic [OP_W-1:0]                     mult_b,
    input  logic [P_W-1:0]                      mult_p,
    output logic [SUM_ABS_W-1:0]                sum_abs_err,
    output logic [P_W-1:0]                      max_abs_err,
    output logic [ERR_CNT_W-1:0]                err_count,
    output logic [SUM_REL_INT_W+FRAC_BITS-1:0]  sum_rel_err,
    output logic [MEAN_REL_INT_W+FRAC_BITS-1:0] mean_rel_err
);

    localparam int QW     = quot_width(FRAC_BITS);
    localparam int SREL_W = SUM_REL_INT_W + FRAC_BITS;
    localparam int MEAN_W = MEAN_REL_INT_W + FRAC_BITS;
    localparam int SET_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [SET_W-1:0]     settle_q, settle_d;
    logic [P_W-1:0]       exact_q, exact_d;
    logic [P_W-1:0]       diff_q, diff_d;
    logic [QW-1:0]        quot_q, quot_d;
    logic                 div_issued_q, div_issued_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [SUM_ABS_W-1:0] sum_abs_q, sum_abs_d;
    logic [P_W-1:0]       max_abs_q, max_abs_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [SREL_W-1:0]    sum_rel_q, sum_rel_d;
    logic [MEAN_W-1:0]    mean_q, mean_d;

    logic                 accept;
    logic                 div_start;
    logic                 div_valid;
    logic [QW-1:0]        div_quotient;
    logic [P_W-1:0]       exact_c;
    logic [P_W-1:0]       diff_c;

    // Operands come straight from the pair-index register.
    assign mult_a = idx_q[IDX_W-1:OP_W];
    assign mult_b = idx_q[OP_W-1:0];

    seq_restoring_div #(
        .DVD_W (QW),
        .DVS_W (P_W)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .dividend ({diff_q, {FRAC_BITS{1'b0}}}),
        .divisor  (exact_q),
        .valid    (div_valid),
        .quotient (div_quotient)
    );

    // Sweep FSM, error datapath and result/status next-state logic.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        settle_d     = settle_q;
        exact_d      = exact_q;
        diff_d       = diff_q;
        quot_d       = quot_q;
        div_issued_d = div_issued_q;
        busy_d       = busy_q;
        done_d       = done_q;
        sum_abs_d    = sum_abs_q;
        max_abs_d    = max_abs_q;
        err_cnt_d    = err_cnt_q;
        sum_rel_d    = sum_rel_q;
        mean_d       = mean_q;
        div_start    = 1'b0;
        accept       = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
        exact_c      = P_W'(mult_a) * P_W'(mult_b);
        diff_c       = (mult_p >= exact_c) ? (mult_p - exact_c) : (exact_c - mult_p);

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    idx_d     = '0;
                    settle_d  = '0;
                    sum_abs_d = '0;
                    max_abs_d = '0;
                    err_cnt_d = '0;
                    sum_rel_d = '0;
                    state_d   = ST_APPLY;
                end
            end
            ST_APPLY: begin
                if (settle_q == SET_W'(SETTLE_CYCLES - 1)) begin
                    settle_d = '0;
                    state_d  = ST_SAMPLE;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            ST_SAMPLE: begin
                exact_d = exact_c;
                diff_d  = diff_c;
                quot_d  = '0;
                // A zero exact product has no defined relative error, and a
                // zero difference needs no division.
                state_d = ((exact_c != '0) && (diff_c != '0)) ? ST_DIVIDE : ST_ACCUM;
            end
            ST_DIVIDE: begin
                div_start    = !div_issued_q;
                div_issued_d = 1'b1;
                if (div_valid) begin
                    quot_d       = div_quotient;
                    div_issued_d = 1'b0;
                    state_d      = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                sum_abs_d = sum_abs_q + SUM_ABS_W'(diff_q);
                if (diff_q > max_abs_q) begin
                    max_abs_d = diff_q;
                end
                if (diff_q != '0) begin
                    err_cnt_d = err_cnt_q + 1'b1;
                end
                sum_rel_d = sum_rel_q + SREL_W'(quot_q);
                if (idx_q == {IDX_W{1'b1}}) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = ST_APPLY;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // The mean is registered from the final sum on the first DONE cycle;
        // done rises together with it so the host never sees a stale mean.
        if (accept) begin
            busy_d = 1'b1;
            done_d = 1'b0;
            mean_d = '0;
        end else if (state_q == ST_DONE) begin
            busy_d = 1'b0;
            done_d = 1'b1;
            mean_d = sum_rel_q[SREL_W-1:IDX_W];
        end
    end

    // State, datapath and result registers; reset aborts any sweep in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            settle_q     <= '0;
            exact_q      <= '0;
            diff_q       <= '0;
            quot_q       <= '0;
            div_issued_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            sum_abs_q    <= '0;
            max_abs_q    <= '0;
            err_cnt_q    <= '0;
            sum_rel_q    <= '0;
            mean_q       <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            settle_q     <= settle_d;
            exact_q      <= exact_d;
            diff_q       <= diff_d;
            quot_q       <= quot_d;
            div_issued_q <= div_issued_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            sum_abs_q    <= sum_abs_d;
            max_abs_q    <= max_abs_d;
            err_cnt_q    <= err_cnt_d;
            sum_rel_q    <= sum_rel_d;
            mean_q       <= mean_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign sum_abs_err  = sum_abs_q;
    assign max_abs_err  = max_abs_q;
    assign err_count    = err_cnt_q;
    assign sum_rel_err  = sum_rel_q;
    assign mean_rel_err = mean_q;

endmodule
